// File: rtl/tl45_muldiv_ctrl.sv
// tl45_muldiv_ctrl: iterative radix-2 multiply/divide sequencer beside the TL45 ALU.
// Product {hi,lo} and remainder/quotient {r,q} share the same hi/lo registers.
module tl45_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pipe_flush,
    input  logic             i_valid,
    input  logic [1:0]       i_op,
    input  logic [3:0]       i_dr,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [3:0]       o_dr,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_by_zero
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    logic [1:0]       state, op;
    logic [3:0]       dr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, b, hi_n, lo_n;
    logic [WIDTH:0]   sum, rw, diff;
    logic             ge, abort;
    // Remainder is kept one bit wider while comparing so divisors with the MSB set stay exact.
    always_comb begin
        sum   = {1'b0, hi} + {1'b0, b & {WIDTH{lo[0]}}};
        rw    = {hi, lo[WIDTH-1]};
        diff  = rw - {1'b0, b};
        ge    = rw >= {1'b0, b};
        hi_n  = op[1] ? (ge ? diff[WIDTH-1:0] : rw[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n  = op[1] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
        abort = i_reset || i_pipe_flush;
    end
    assign o_busy = !abort && (state != S_IDLE || i_valid);
    always_ff @(posedge i_clk) begin
        if (abort) begin
            state         <= S_IDLE;
            op            <= '0;
            dr            <= '0;
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            b             <= '0;
            o_valid       <= 1'b0;
            o_dr          <= '0;
            o_result      <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_valid       <= 1'b0;
            o_dr          <= '0;
            o_result      <= '0;
            o_div_by_zero <= 1'b0;
            if (state == S_IDLE && i_valid) begin
                op  <= i_op;
                dr  <= i_dr;
                b   <= i_b;
                hi  <= '0;
                lo  <= i_a;
                cnt <= '0;
                if (i_op[1] && i_b == '0) begin
                    state         <= S_DONE;
                    o_valid       <= 1'b1;
                    o_dr          <= i_dr;
                    o_result      <= i_op[0] ? i_a : '1;
                    o_div_by_zero <= 1'b1;
                end else begin
                    state <= S_RUN;
                end
            end else if (state == S_RUN) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state    <= S_DONE;
                    o_valid  <= 1'b1;
                    o_dr     <= dr;
                    o_result <= op[0] ? hi_n : lo_n;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_tl45_muldiv_ctrl.sv
// tb_tl45_muldiv_ctrl: directed and random ops checked cycle-by-cycle against an arithmetic model.
module tb_tl45_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, valid;
    logic [1:0]  op;
    logic [3:0]  dr;
    logic [31:0] a, b;
    logic        busy, o_valid, o_dz;
    logic [3:0]  o_dr;
    logic [31:0] o_result;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tl45_muldiv_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_pipe_flush(flush), .i_valid(valid),
        .i_op(op), .i_dr(dr), .i_a(a), .i_b(b),
        .o_busy(busy), .o_valid(o_valid), .o_dr(o_dr), .o_result(o_result),
        .o_div_by_zero(o_dz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Issues one op; abort_at >= 0 raises reset (abort_rst) or flush in that cycle relative to issue.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] d, input bit nw, input int abort_at, input bit abort_rst);
        int lat;
        logic [31:0] exp_r;
        lat   = (o[1] && y == 0) ? 1 : 33;
        exp_r = model(o, x, y);
        if (!nw) @(negedge clk);
        valid = 1'b1; op = o; a = x; b = y; dr = d;
        if (abort_at == 0) begin rst = abort_rst; flush = !abort_rst; end
        #1;
        chk("busy_issue", 64'(busy), (abort_at == 0) ? 64'd0 : 64'd1);
        for (int k = 1; k <= lat && abort_at != 0; k++) begin
            @(negedge clk);
            valid = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom; dr = 4'($urandom);
            if (k == abort_at) begin rst = abort_rst; flush = !abort_rst; end
            #1;
            if (k == abort_at) begin
                chk("busy_abort", 64'(busy), 64'd0);
                chk("valid_abort", 64'(o_valid), (k == lat) ? 64'd1 : 64'd0);
                break;
            end
            if (k < lat) chk("run", 64'({o_valid, busy}), 64'b01);
            else begin
                chk("done_valid", 64'({o_valid, busy}), 64'b11);
                chk("done_dr", 64'(o_dr), 64'(d));
                chk("done_result", 64'(o_result), 64'(exp_r));
                chk("done_dz", 64'(o_dz), 64'(o[1] && y == 0));
            end
        end
        @(negedge clk);
        valid = 1'b0; rst = 1'b0; flush = 1'b0;
        #1;
        chk("after_idle", 64'({o_valid, o_dr, o_result, o_dz, busy}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; op = '0; dr = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({o_valid, o_dr, o_result, o_dz, busy}), 64'd0);
        rst = 1'b0;
        run_op(2'd0, 32'd7, 32'd6, 4'd3, 0, -1, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 0, -1, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1, -1, 0);
        run_op(2'd2, 32'd100, 32'd7, 4'd4, 0, -1, 0);
        run_op(2'd3, 32'd100, 32'd7, 4'd5, 0, -1, 0);
        run_op(2'd2, 32'd5, 32'd0, 4'd6, 0, -1, 0);
        run_op(2'd3, 32'd5, 32'd0, 4'd7, 0, -1, 0);
        run_op(2'd0, 32'd3, 32'd5, 4'd8, 0, 10, 0);
        run_op(2'd2, 32'd9, 32'd2, 4'd9, 1, -1, 0);
        run_op(2'd0, 32'd11, 32'd13, 4'd10, 0, 33, 1);
        run_op(2'd1, 32'd11, 32'd13, 4'd11, 1, 0, 1);
        run_op(2'd2, 32'd77, 32'd0, 4'd12, 1, 1, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 4'd13, 0, -1, 0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ry;
            case ($urandom_range(3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(255));
                default: ry = $urandom;
            endcase
            run_op(2'($urandom), $urandom, ry, 4'($urandom), 1'($urandom), -1, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
